serial_adder_subtractor: RTL and testbench

SERIAL_ADDER_SUBTRACTOR -- requirements
Module: serial_adder_subtractor

---
 rtl/serial_adder_subtractor.sv | 131 +++++++++++++
 tb/tb_serial_adder_subtractor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_subtractor.sv
// Bit-serial adder/subtractor.
// One full-adder cell processes one bit per clock, LSB first. Subtraction
// is a + ~b + 1: the b input of the cell is inverted by opcode and the carry
// register is seeded with opcode on acceptance.
//
// Handshake: start is sampled only while ready=1. The edge that sees
// ready=1 and start=1 latches a, b and opcode. The operation then runs
// WIDTH clocks with busy=1, followed by a single cycle with done=1. result,
// cout and overflow change only on the edge that processes the MSB, and they
// hold until the next completion.
//
// The one-hot decodes ready/busy/done expose the FSM state directly.

module serial_adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // r_a shifts right each bit; the freed MSB receives the new sum bit, so
  // after WIDTH shifts it holds the complete sum.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic w_accept;
  logic w_last;
  logic w_a_bit;
  logic w_b_in;
  logic w_sum;
  logic w_carry_next;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_last       = (r_cnt == LAST_BIT);
  assign w_a_bit      = r_a[0];
  assign w_b_in       = r_b[0] ^ r_op;
  assign w_sum        = w_a_bit ^ w_b_in ^ r_carry;
  assign w_carry_next = (w_a_bit & w_b_in) | (w_a_bit & r_carry) | (w_b_in & r_carry);

  // State register; reset overrides everything including a same-edge start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on MSB, DONE -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, per-bit shifting and carry propagation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= opcode;
      r_carry <= opcode;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= {w_sum, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_carry <= w_carry_next;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Visible results update only on the edge that processes the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_result <= {w_sum, r_a[WIDTH-1:1]};
      r_cout   <= w_carry_next;
      // Carry into the MSB is the current carry register.
      r_ovf    <= r_carry ^ w_carry_next;
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed bench for serial_adder_subtractor at WIDTH=8: a vector table of
// hand-computed sums/differences plus sequences for start-during-run and
// reset abort.

module tb_serial_adder_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks;
  int errors;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[10];

  serial_adder_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for ready, then present one start for a single edge.
  task automatic issue(input logic op, input logic [W-1:0] va, input logic [W-1:0] vb);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready=%0b, expected 1", ready);
    end
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    a      = va;
    b      = vb;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Count edges from acceptance to done, checking that outputs hold during RUN.
  task automatic finish_op(input string name, input logic [W-1:0] er,
                           input logic ec, input logic eo);
    int lat;
    logic [W-1:0] prev;
    logic held;
    prev = result;
    held = 1'b1;
    lat  = 0;
    while (done !== 1'b1 && lat < 3 * W) begin
      if (result !== prev) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, W);
    check({name, "_hold"}, held, 1'b1);
    check({name, "_result"}, result, er);
    check({name, "_cout"}, cout, ec);
    check({name, "_ovf"}, overflow, eo);
    @(posedge clk); #1;
    check({name, "_done_1cyc"}, done, 1'b0);
    check({name, "_ready_after"}, ready, 1'b1);
  endtask

  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 1'b0;
    a      = '0;
    b      = '0;

    vecs[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), busy, 1'b1);
      finish_op($sformatf("v%0d", i), vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // Start and operand changes during RUN/DONE are ignored
    issue(1'b0, 8'h05, 8'h03);
    start  = 1'b1;
    opcode = 1'b1;
    a      = 8'hF0;
    b      = 8'h0F;
    pulses = 0;
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    check("ign_pulses", pulses, 1);
    check("ign_result", result, 8'h08);
    check("ign_cout", cout, 1'b0);
    check("ign_ovf", overflow, 1'b0);
    check("ign_ready", ready, 1'b1);

    // Reset at bit 4 of a run aborts without a done or output update
    issue(1'b0, 8'h3C, 8'h21);
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy", busy, 1'b1);
    check("abort_prev_result", result, 8'h08);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", ready, 1'b1);
    check("abort_busy_after", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 8'h00);
    check("abort_cout", cout, 1'b0);
    check("abort_ovf", overflow, 1'b0);
    @(posedge clk); #1;
    check("rst_start_ignored", ready, 1'b1);
    reset = 1'b0;
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);

    issue(1'b0, 8'h01, 8'h01);
    finish_op("post_abort", 8'h02, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
